// File: rtl/riscv_run_pkg.sv
// Shared types for the RISC-V run controller: FSM states, run modes, stop causes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RESET_HOLD = 3'd1,
    ST_RUN        = 3'd2,
    ST_STEP_WAIT  = 3'd3,
    ST_DONE       = 3'd4
  } run_state_e;

  typedef enum logic [1:0] {
    MODE_FREE  = 2'd0,
    MODE_LIMIT = 2'd1,
    MODE_STEP  = 2'd2,
    MODE_RSVD  = 2'd3
  } run_mode_e;

  typedef enum logic [2:0] {
    CAUSE_NONE   = 3'd0,
    CAUSE_EBREAK = 3'd1,
    CAUSE_HALT   = 3'd2,
    CAUSE_STALL  = 3'd3,
    CAUSE_LIMIT  = 3'd4,
    CAUSE_SAT    = 3'd5
  } done_cause_e;

  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

  // The reserved mode code behaves exactly like free-run, so fold it at latch time.
  function automatic run_mode_e norm_mode(input logic [1:0] m);
    return (m == MODE_RSVD) ? MODE_FREE : run_mode_e'(m);
  endfunction

endpackage

// File: rtl/riscv_run_ctrl_if.sv
// Bundle between the run controller, its host (start/mode/step/status) and the core (pc/instr/reset/ce).
// Latency: n/a (wiring only).
// Backpressure: none; step is a level, start a 1-cycle pulse.
// Ports: master = controller side (drives core_reset/core_ce/status), slave = host/core side.
interface riscv_run_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             start;
  logic [1:0]       mode;
  logic             step;
  logic [CNT_W-1:0] run_limit;
  logic [XLEN-1:0]  halt_addr;
  logic [XLEN-1:0]  pc;
  logic [31:0]      instr;
  logic             core_reset;
  logic             core_ce;
  logic             busy;
  logic             done;
  logic [2:0]       done_cause;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    input  start, mode, step, run_limit, halt_addr, pc, instr,
    output core_reset, core_ce, busy, done, done_cause, cycle_count
  );

  modport slave (
    output start, mode, step, run_limit, halt_addr, pc, instr,
    input  core_reset, core_ce, busy, done, done_cause, cycle_count
  );
endinterface

// File: rtl/riscv_stall_detect.sv
// Flags a self-loop: STALL_LIM consecutive enabled cycles whose PC equals the previous enabled PC.
// Latency: stall is registered state, visible the cycle after the qualifying enabled cycle.
// Backpressure: none; only advances on en.
// Ports: clk, reset (sync, active-high), clr (per-run clear), en (core committed), pc, stall (out).
module riscv_stall_detect #(
  parameter int XLEN      = 32,
  parameter int STALL_LIM = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            en,
  input  logic [XLEN-1:0] pc,
  output logic            stall
);

  localparam int SC_W = $clog2(STALL_LIM + 1);

  logic [XLEN-1:0] pc_prev;
  logic [SC_W-1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      pc_prev   <= '0;
      stall_cnt <= '0;
    end else if (en) begin
      pc_prev <= pc;
      if (pc == pc_prev) begin
        // Hold at the limit; the controller stops enabling once stall is set anyway.
        if (stall_cnt != SC_W'(STALL_LIM))
          stall_cnt <= stall_cnt + SC_W'(1);
      end else begin
        stall_cnt <= '0;
      end
    end
  end

  assign stall = (stall_cnt >= SC_W'(STALL_LIM));

endmodule

// File: rtl/riscv_run_ctrl.sv
// Run controller: holds the core in reset, then clock-enables it in free-run, cycle-limited or single-step mode until a stop condition.
// Latency: core_ce is combinational from pc/instr (stopping instruction never commits); all other outputs registered.
// Backpressure: start ignored while busy; step grants one cycle per rising edge.
// Ports: clk, reset (sync, active-high), bus (riscv_run_ctrl_if.master: host controls/status and core pc/instr/reset/ce).
module riscv_run_ctrl
  import riscv_run_pkg::*;
#(
  parameter int RST_CYCLES = 50,
  parameter int XLEN       = 32,
  parameter int CNT_W      = 32,
  parameter int STALL_LIM  = 16
) (
  input  logic              clk,
  input  logic              reset,
  riscv_run_ctrl_if.master  bus
);

  localparam int HOLD_W = $clog2(RST_CYCLES + 1);

  run_state_e       state_q, state_d;
  run_mode_e        mode_q;
  logic [CNT_W-1:0] limit_q;
  logic [XLEN-1:0]  halt_q;
  logic [CNT_W-1:0] cnt_q;
  logic [HOLD_W-1:0] hold_q;
  done_cause_e      cause_q;
  done_cause_e      stop_cause;
  logic             step_q;
  logic             core_reset_q;
  logic             busy_q;
  logic             done_q;

  logic             stall;
  logic             stop;
  logic             step_rise;
  logic             hold_last;
  logic             ce;
  logic             launch;
  logic             latch_cause;

  assign step_rise = bus.step & ~step_q;
  assign hold_last = (hold_q == HOLD_W'(RST_CYCLES - 1));

  riscv_stall_detect #(
    .XLEN      (XLEN),
    .STALL_LIM (STALL_LIM)
  ) u_stall (
    .clk   (clk),
    .reset (reset),
    .clr   (launch),
    .en    (ce),
    .pc    (bus.pc),
    .stall (stall)
  );

  // Stop evaluation on the instruction currently presented; first match wins.
  always_comb begin
    stop_cause = CAUSE_NONE;
    if (bus.instr == EBREAK_INSN)
      stop_cause = CAUSE_EBREAK;
    else if (bus.pc == halt_q)
      stop_cause = CAUSE_HALT;
    else if (stall)
      stop_cause = CAUSE_STALL;
    else if ((mode_q == MODE_LIMIT) && (cnt_q == limit_q))
      stop_cause = CAUSE_LIMIT;
    else if (cnt_q == '1)
      stop_cause = CAUSE_SAT;
  end

  assign stop = (stop_cause != CAUSE_NONE);

  always_comb begin
    state_d     = state_q;
    ce          = 1'b0;
    launch      = 1'b0;
    latch_cause = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          launch  = 1'b1;
          state_d = ST_RESET_HOLD;
        end
      end
      ST_RESET_HOLD: begin
        if (hold_last)
          state_d = (mode_q == MODE_STEP) ? ST_STEP_WAIT : ST_RUN;
      end
      ST_RUN: begin
        if (stop) begin
          latch_cause = 1'b1;
          state_d     = ST_DONE;
        end else begin
          ce = 1'b1;
        end
      end
      ST_STEP_WAIT: begin
        // Stop is only acted on when a step is requested.
        if (step_rise) begin
          if (stop) begin
            latch_cause = 1'b1;
            state_d     = ST_DONE;
          end else begin
            ce = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          launch  = 1'b1;
          state_d = ST_RESET_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_FREE;
      limit_q      <= '0;
      halt_q       <= '0;
      cnt_q        <= '0;
      hold_q       <= '0;
      cause_q      <= CAUSE_NONE;
      step_q       <= 1'b0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      // Edge detector runs in every state so an edge seen during reset hold is consumed there.
      step_q  <= bus.step;

      if (launch) begin
        mode_q  <= norm_mode(bus.mode);
        limit_q <= bus.run_limit;
        halt_q  <= bus.halt_addr;
        cnt_q   <= '0;
        cause_q <= CAUSE_NONE;
        hold_q  <= '0;
      end else begin
        if ((state_q == ST_RESET_HOLD) && !hold_last)
          hold_q <= hold_q + HOLD_W'(1);
        // Saturation is a stop cause, so ce is never high at all-ones.
        if (ce)
          cnt_q <= cnt_q + CNT_W'(1);
        if (latch_cause)
          cause_q <= stop_cause;
      end

      core_reset_q <= (state_d == ST_IDLE) || (state_d == ST_RESET_HOLD);
      busy_q       <= (state_d == ST_RESET_HOLD) || (state_d == ST_RUN) ||
                      (state_d == ST_STEP_WAIT);
      done_q       <= (state_d == ST_DONE);
    end
  end

  assign bus.core_reset  = core_reset_q;
  assign bus.core_ce     = ce;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.done_cause  = cause_q;
  assign bus.cycle_count = cnt_q;

endmodule
